// File: rtl/mod_n_count_scheduler_if.sv
// Command handshake between two requesters and the mod-N count scheduler.
// Signal names keep the scheduler's port-level i_/o_ naming for traceability.
interface mod_n_count_scheduler_if #(
    parameter int STEP_W = 4
);
    logic [1:0]        i_valid;
    logic [1:0]        i_up;
    logic [STEP_W-1:0] i_steps0;
    logic [STEP_W-1:0] i_steps1;
    logic [1:0]        o_ready;

    modport master (
        output i_valid,
        output i_up,
        output i_steps0,
        output i_steps1,
        input  o_ready
    );

    modport slave (
        input  i_valid,
        input  i_up,
        input  i_steps0,
        input  i_steps1,
        output o_ready
    );
endinterface

// File: rtl/mod_n_count_scheduler.sv
// Round-robin scheduler of "count D for S steps" commands onto a shared
// mod-N up/down counter, with a shadow position and per-requester completion.
module mod_n_count_scheduler #(
    parameter int WIDTH  = 3,
    parameter int N      = 6,
    parameter int STEP_W = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    mod_n_count_scheduler_if.slave   cmd,
    input  logic                     i_hold,
    output logic                     o_cnt_en,
    output logic                     o_cnt_up,
    output logic [WIDTH-1:0]         o_pos,
    output logic                     o_wrap,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_done_id
);

    localparam logic [WIDTH-1:0] POS_MAX = WIDTH'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic                rr_q;
    logic                dir_q;
    logic                id_q;
    logic [STEP_W-1:0]   rem_q;
    logic [WIDTH-1:0]    pos_q;
    logic                wrap_q;
    logic                done_q;
    logic                done_id_q;

    logic                win;
    logic                accept;
    logic                sel_up;
    logic [STEP_W-1:0]   sel_steps;
    logic                cnt_en;
    logic                step_wraps;
    logic [WIDTH-1:0]    pos_d;
    logic [STEP_W-1:0]   rem_d;

    // Winner: the sole requester, or the rr pointer on contention.
    always_comb begin
        win       = (cmd.i_valid == 2'b11) ? rr_q : cmd.i_valid[1];
        accept    = (state_q == S_IDLE) && (|cmd.i_valid);
        sel_up    = cmd.i_up[win];
        sel_steps = win ? cmd.i_steps1 : cmd.i_steps0;
    end

    assign cmd.o_ready = accept ? (win ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        cnt_en     = (state_q == S_RUN) && !i_hold;
        step_wraps = dir_q ? (pos_q == POS_MAX) : (pos_q == '0);
        if (dir_q) begin
            pos_d = step_wraps ? '0 : pos_q + WIDTH'(1);
        end else begin
            pos_d = step_wraps ? POS_MAX : pos_q - WIDTH'(1);
        end
        rem_d = (rem_q != '0) ? rem_q - STEP_W'(1) : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            rr_q      <= 1'b0;
            dir_q     <= 1'b0;
            id_q      <= 1'b0;
            rem_q     <= '0;
            pos_q     <= '0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        dir_q <= sel_up;
                        id_q  <= win;
                        rem_q <= sel_steps;
                        if (sel_steps != '0) begin
                            state_q <= S_RUN;
                        end else begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            done_id_q <= win;
                        end
                    end
                end
                S_RUN: begin
                    if (cnt_en) begin
                        pos_q  <= pos_d;
                        wrap_q <= step_wraps;
                        rem_q  <= rem_d;
                        // rem_q of 0 cannot occur here; treat it as finished anyway.
                        if (rem_q <= STEP_W'(1)) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            done_id_q <= id_q;
                        end
                    end
                end
                S_DONE: begin
                    rr_q    <= ~id_q;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cnt_en  = cnt_en;
    assign o_cnt_up  = (state_q == S_RUN) && dir_q;
    assign o_pos     = pos_q;
    assign o_wrap    = wrap_q;
    assign o_busy    = (state_q != S_IDLE);
    assign o_done    = done_q;
    assign o_done_id = done_id_q;

endmodule

// File: tb/tb_mod_n_count_scheduler.sv
// Directed bench for mod_n_count_scheduler (WIDTH=3, N=6, STEP_W=4).
module tb_mod_n_count_scheduler;

    logic       clk;
    logic       rst;
    logic       hold;
    logic       cnt_en;
    logic       cnt_up;
    logic [2:0] pos;
    logic       wrap;
    logic       busy;
    logic       done;
    logic       done_id;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pos  = 0;
    bit exp_wrap = 0;
    int wrap_seen = 0;

    mod_n_count_scheduler_if #(.STEP_W(4)) cmd_if ();

    mod_n_count_scheduler #(.WIDTH(3), .N(6), .STEP_W(4)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .cmd       (cmd_if.slave),
        .i_hold    (hold),
        .o_cnt_en  (cnt_en),
        .o_cnt_up  (cnt_up),
        .o_pos     (pos),
        .o_wrap    (wrap),
        .o_busy    (busy),
        .o_done    (done),
        .o_done_id (done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Issue one command from requester r and follow it to completion.
    // Called just after a rising edge. hold_at = steps taken before holding.
    task automatic run_cmd(input int r, input bit up, input int steps,
                           input int hold_at, input int hold_len,
                           input int exp_lat, input int exp_final);
        int  k = 0;
        int  hc = 0;
        bit  got = 0;
        bit  hold_now;
        cmd_if.i_valid  = (r == 1) ? 2'b10 : 2'b01;
        cmd_if.i_up     = up ? 2'b11 : 2'b00;
        cmd_if.i_steps0 = (r == 0) ? 4'(steps) : 4'hF;
        cmd_if.i_steps1 = (r == 1) ? 4'(steps) : 4'hF;
        exp_wrap = 0;
        @(negedge clk);
        check("ready_grant", int'(cmd_if.o_ready), (r == 1) ? 2 : 1);
        @(posedge clk); #1;
        cmd_if.i_valid = 2'b00;
        for (int lat = 1; lat <= 40; lat++) begin
            hold_now = (k == hold_at) && (hc < hold_len);
            hold = hold_now;
            @(negedge clk);
            if (wrap) wrap_seen++;
            if (done) begin
                got = 1;
                check("done_id", int'(done_id), r);
                check("done_latency", lat, exp_lat);
                check("final_pos", int'(pos), exp_final);
                check("done_cnt_en", int'(cnt_en), 0);
                check("done_wrap", int'(wrap), int'(exp_wrap));
                break;
            end
            check("run_cnt_en", int'(cnt_en), int'(!hold_now));
            check("run_cnt_up", int'(cnt_up), int'(up));
            check("run_pos", int'(pos), exp_pos);
            check("run_wrap", int'(wrap), int'(exp_wrap));
            check("run_busy", int'(busy), 1);
            check("run_ready", int'(cmd_if.o_ready), 0);
            @(posedge clk); #1;
            if (hold_now) begin
                hc++;
                exp_wrap = 0;
            end else begin
                k++;
                if (up) begin
                    exp_wrap = (exp_pos == 5);
                    exp_pos  = (exp_pos == 5) ? 0 : exp_pos + 1;
                end else begin
                    exp_wrap = (exp_pos == 0);
                    exp_pos  = (exp_pos == 0) ? 5 : exp_pos - 1;
                end
            end
        end
        hold = 1'b0;
        if (!got) check("done_timeout", 0, 1);
        @(posedge clk); #1;
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
        $display("cmd r=%0d up=%0d S=%0d hold=%0d -> pos=%0d", r, up, steps, hold_len, pos);
    endtask

    initial begin
        int done_cnt;
        logic [1:0] rr_exp;
        rst  = 1'b1;
        hold = 1'b0;
        cmd_if.i_valid  = 2'b00;
        cmd_if.i_up     = 2'b00;
        cmd_if.i_steps0 = 4'd0;
        cmd_if.i_steps1 = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_pos", int'(pos), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_wrap", int'(wrap), 0);
        check("rst_cnt_en", int'(cnt_en), 0);
        check("rst_ready", int'(cmd_if.o_ready), 0);
        @(posedge clk); #1;

        // Basic up count, then approach and cross the wrap point.
        run_cmd(0, 1'b1, 3, -1, 0, 4, 3);
        run_cmd(0, 1'b1, 1, -1, 0, 2, 4);
        wrap_seen = 0;
        run_cmd(1, 1'b1, 3, -1, 0, 4, 1);
        check("wrap_pulses", wrap_seen, 1);

        // Round-robin alternation with both requesters asserting continuously.
        rst = 1'b1; #2; rst = 1'b0;
        exp_pos = 0;
        @(posedge clk); #1;
        cmd_if.i_valid  = 2'b11;
        cmd_if.i_up     = 2'b11;
        cmd_if.i_steps0 = 4'd1;
        cmd_if.i_steps1 = 4'd2;
        for (int c = 0; c < 4; c++) begin
            rr_exp = (c % 2 == 1) ? 2'b10 : 2'b01;
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                if (cmd_if.o_ready != 2'b00) break;
            end
            check("rr_ready", int'(cmd_if.o_ready), int'(rr_exp));
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                if (done) break;
            end
            check("rr_done", int'(done), 1);
            check("rr_done_id", int'(done_id), c % 2);
            $display("rr cmd %0d granted ready=%b done_id=%0d", c, cmd_if.o_ready, done_id);
        end
        @(posedge clk); #1;
        cmd_if.i_valid = 2'b00;
        check("rr_final_pos", int'(pos), 0);

        // Down with a two-cycle hold after the first step, then S=0.
        run_cmd(0, 1'b0, 2, 1, 2, 5, 4);
        run_cmd(1, 1'b1, 0, -1, 0, 1, 4);

        // Reset in the middle of a long command.
        cmd_if.i_valid  = 2'b01;
        cmd_if.i_up     = 2'b01;
        cmd_if.i_steps0 = 4'd8;
        @(posedge clk); #1;
        cmd_if.i_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("midrun_pos", int'(pos), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_pos", int'(pos), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_cnt_en", int'(cnt_en), 0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("arst_no_done", done_cnt, 0);
        $display("reset mid-run: pos=%0d busy=%0d done pulses=%0d", pos, busy, done_cnt);
        exp_pos = 0;
        @(posedge clk); #1;
        run_cmd(1, 1'b1, 2, -1, 0, 3, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
